// File: rtl/out_seq_pkg.sv
// Shared types and helpers for the output write-back sequencer.
// Holds the FSM encoding, legal parameter ranges and the address function.
package out_seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_t;

  localparam int LAT_MIN  = 2;
  localparam int LAT_MAX  = 8;
  localparam int PEND_MAX = 3;

  // Channel-major: ct*os+wi.  Window-major: wi*(od+1)+ct.  Caller truncates.
  function automatic logic [31:0] out_addr(input logic [31:0] ct,
                                           input logic [31:0] wi,
                                           input logic [31:0] od,
                                           input logic [31:0] os,
                                           input logic        interleave);
    return interleave ? (wi * (od + 32'd1) + ct) : (ct * os + wi);
  endfunction

endpackage

// File: rtl/out_seq_pipe.sv
// LAT-stage delay line carrying {valid, first, addr} from issue to write-back.
// Always advances; rst clears every stage so nothing in flight survives.
module out_seq_pipe #(
  parameter int LAT = 3,
  parameter int AW  = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          in_first,
  input  logic [AW-1:0] in_addr,
  output logic          s1_valid,
  output logic          dly_valid,
  output logic          dly_first,
  output logic [AW-1:0] dly_addr
);

  logic [LAT-1:0] valid_q;
  logic [LAT-1:0] first_q;
  logic [AW-1:0]  addr_q [LAT];

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples its predecessor's pre-edge value and the shift stays ordered.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      first_q <= '0;
      for (int i = 0; i < LAT; i++) addr_q[i] <= '0;
    end else begin
      valid_q   <= {valid_q[LAT-2:0], in_valid};
      first_q   <= {first_q[LAT-2:0], in_first};
      addr_q[0] <= in_addr;
      for (int i = 1; i < LAT; i++) addr_q[i] <= addr_q[i-1];
    end
  end

  assign s1_valid  = valid_q[0];
  assign dly_valid = valid_q[LAT-1];
  assign dly_first = first_q[LAT-1];
  assign dly_addr  = addr_q[LAT-1];

endmodule

// File: rtl/out_seq_ctrl.sv
// Output write-back sequencer: one channel sweep per queued k_fin, with
// back-pressure, a small request queue, sticky overflow and two address modes.
module out_seq_ctrl
  import out_seq_pkg::*;
#(
  parameter int CH_W = 4,
  parameter int WI_W = 10,
  parameter int AW   = 12,
  parameter int LAT  = 3,
  parameter int PEND = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_init,
  input  logic            k_fin,
  input  logic            dst_acc,
  input  logic            interleave,
  input  logic [CH_W-1:0] od,
  input  logic [WI_W-1:0] os,
  input  logic            out_ready,
  output logic            outr,
  output logic            accr,
  output logic [AW-1:0]   oa,
  output logic            update,
  output logic            out_busy,
  output logic            ovf
);

  localparam logic [1:0] PEND_V = 2'(PEND);

  seq_state_t      state_q, state_d;
  logic [CH_W-1:0] ct_q, od_q;
  logic [WI_W-1:0] wi_q, os_q, os_eff;
  logic            il_q;
  logic [1:0]      pcnt_q;
  logic            issue, last, start, accept;
  logic [AW-1:0]   issue_addr;
  logic            p_s1_valid, p_valid, p_first;
  logic [AW-1:0]   p_addr;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first so no path
  // through the case leaves it unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (pcnt_q != 2'd0) state_d = RUN;
      RUN:  if (issue && last && pcnt_q == 2'd0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    issue    = (state_q == RUN) && out_ready;
    last     = (ct_q == od_q);
    start    = (pcnt_q != 2'd0) && ((state_q == IDLE) || (issue && last));
    out_busy = (state_q == RUN) || (pcnt_q != 2'd0);
  end

  // A start in the same cycle frees a slot, so a k_fin at a full queue is kept.
  assign accept = k_fin && ((pcnt_q != PEND_V) || start);
  assign os_eff = (os_q == '0) ? WI_W'(1) : os_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q <= '0;
      ovf    <= 1'b0;
      ct_q   <= '0;
      wi_q   <= '0;
      od_q   <= '0;
      os_q   <= '0;
      il_q   <= 1'b0;
    end else begin
      case ({accept, start})
        2'b10:   pcnt_q <= pcnt_q + 2'd1;
        2'b01:   pcnt_q <= pcnt_q - 2'd1;
        default: pcnt_q <= pcnt_q;
      endcase
      if (k_fin && !accept) ovf <= 1'b1;

      if (start) begin
        ct_q <= '0;
        od_q <= od;
        os_q <= os;
        il_q <= interleave;
      end else if (issue && !last) begin
        ct_q <= ct_q + 1'b1;
      end

      if (s_init) begin
        wi_q <= '0;
      end else if (issue && last) begin
        wi_q <= (wi_q >= os_eff - 1'b1) ? '0 : wi_q + 1'b1;
      end
    end
  end

  assign issue_addr = AW'(out_addr(32'(ct_q), 32'(wi_q), 32'(od_q), 32'(os_q), il_q));

  out_seq_pipe #(
    .LAT (LAT),
    .AW  (AW)
  ) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (issue),
    .in_first  (issue && (ct_q == '0)),
    .in_addr   (issue ? issue_addr : '0),
    .s1_valid  (p_s1_valid),
    .dly_valid (p_valid),
    .dly_first (p_first),
    .dly_addr  (p_addr)
  );

  assign outr   = p_valid;
  assign oa     = p_valid ? p_addr : '0;
  assign update = p_valid && p_first;
  assign accr   = p_s1_valid && dst_acc;

endmodule

// File: tb/tb_out_seq_ctrl.sv
// Randomised bench for out_seq_ctrl against a transaction-level reference model
// plus directed sweeps with hand-computed address sequences.
module tb_out_seq_ctrl;

  localparam int CH_W = 4;
  localparam int WI_W = 10;
  localparam int AW   = 12;
  localparam int LAT  = 3;
  localparam int PEND = 2;

  logic            clk = 1'b0;
  logic            rst, s_init, k_fin, dst_acc, interleave, out_ready;
  logic [CH_W-1:0] od;
  logic [WI_W-1:0] os;
  logic            outr, accr, update, out_busy, ovf;
  logic [AW-1:0]   oa;

  always #5 clk = ~clk;

  out_seq_ctrl #(
    .CH_W (CH_W), .WI_W (WI_W), .AW (AW), .LAT (LAT), .PEND (PEND)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_init     (s_init),
    .k_fin      (k_fin),
    .dst_acc    (dst_acc),
    .interleave (interleave),
    .od         (od),
    .os         (os),
    .out_ready  (out_ready),
    .outr       (outr),
    .accr       (accr),
    .oa         (oa),
    .update     (update),
    .out_busy   (out_busy),
    .ovf        (ovf)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // Reference model: a request counter, the current sweep, and a timeline of
  // expected write-backs keyed by the cycle they must appear in.
  typedef struct {
    int due;
    int addr;
    bit first;
  } wb_t;

  wb_t q[$];
  int  cap[$];
  int  cyc = 0;
  bit  m_run, m_ovf, m_iss_prev;
  int  m_ct, m_wi, m_pcnt, m_od, m_os, m_il;
  int  n_outr, n_upd;

  task automatic model_reset();
    m_run = 0; m_ovf = 0; m_iss_prev = 0;
    m_ct = 0; m_wi = 0; m_pcnt = 0; m_od = 0; m_os = 0; m_il = 0;
    q.delete();
  endtask

  task automatic model_edge();
    bit iss, lst, strt, acc;
    int a, os_e;
    cyc++;
    if (rst) begin
      model_reset();
      return;
    end
    iss  = m_run && out_ready;
    lst  = iss && (m_ct == m_od);
    strt = (m_pcnt != 0) && (!m_run || lst);
    acc  = k_fin && ((m_pcnt < PEND) || strt);
    m_iss_prev = iss;
    if (iss) begin
      a = m_il ? (m_wi * (m_od + 1) + m_ct) : (m_ct * m_os + m_wi);
      q.push_back('{due: cyc + LAT - 1, addr: a % (1 << AW), first: (m_ct == 0)});
    end
    m_pcnt = m_pcnt + int'(acc) - int'(strt);
    if (k_fin && !acc) m_ovf = 1;
    os_e = (m_os == 0) ? 1 : m_os;
    if (s_init) m_wi = 0;
    else if (lst) m_wi = (m_wi + 1 >= os_e) ? 0 : m_wi + 1;
    if (strt) begin
      m_run = 1; m_ct = 0; m_od = int'(od); m_os = int'(os); m_il = int'(interleave);
    end else if (lst) begin
      m_run = 0;
    end else if (iss) begin
      m_ct++;
    end
  endtask

  task automatic check_outputs();
    bit e_outr, e_upd;
    int e_oa;
    e_outr = 0; e_upd = 0; e_oa = 0;
    if (q.size() > 0 && q[0].due == cyc) begin
      e_outr = 1; e_oa = q[0].addr; e_upd = q[0].first;
      void'(q.pop_front());
    end
    check("outr", 32'(outr), 32'(e_outr));
    check("oa", 32'(oa), 32'(e_oa));
    check("update", 32'(update), 32'(e_upd));
    check("accr", 32'(accr), 32'(m_iss_prev && dst_acc));
    check("out_busy", 32'(out_busy), 32'(m_run || m_pcnt != 0));
    check("ovf", 32'(ovf), 32'(m_ovf));
    if (outr) begin
      cap.push_back(int'(oa));
      n_outr++;
    end
    if (update) n_upd++;
  endtask

  // Inputs are set at the falling edge; the model consumes them, the rising
  // edge registers them, and outputs are compared at the next falling edge.
  task automatic tick();
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic rand_tick(input int p_k, input int p_r, input int p_s, input int p_rst);
    k_fin     = ($urandom_range(99) < p_k);
    out_ready = ($urandom_range(99) < p_r);
    s_init    = ($urandom_range(99) < p_s);
    rst       = ($urandom_range(999) < p_rst);
    dst_acc   = $urandom_range(1);
    if ($urandom_range(9) < 2) begin
      interleave = $urandom_range(1);
      od         = CH_W'($urandom_range(15));
      os         = interleave ? WI_W'($urandom_range(5)) : WI_W'($urandom_range(20, 1));
    end
    tick();
  endtask

  task automatic idle_inputs();
    rst = 0; s_init = 0; k_fin = 0; out_ready = 1; dst_acc = 1;
  endtask

  task automatic do_reset();
    rst = 1;
    repeat (2) tick();
    rst = 0;
  endtask

  task automatic directed_sweep(input bit il, input int e0, input int e1, input int e2, input int e3);
    int exp_a[4];
    exp_a = '{e0, e1, e2, e3};
    od = 4'd3; os = 10'd4; interleave = il;
    cap.delete(); n_upd = 0;
    k_fin = 1; tick();
    k_fin = 0;
    repeat (10) tick();
    check("sweep_len", 32'(cap.size()), 32'd4);
    check("sweep_upd", 32'(n_upd), 32'd1);
    for (int i = 0; i < 4; i++)
      if (i < cap.size()) check("sweep_oa", 32'(cap[i]), 32'(exp_a[i]));
  endtask

  initial begin
    model_reset();
    idle_inputs();
    od = '0; os = '0; interleave = 0;
    do_reset();

    // wi advances 0 -> 1 -> 2 across the first two sweeps.
    directed_sweep(1'b0, 0, 4, 8, 12);
    directed_sweep(1'b0, 1, 5, 9, 13);
    directed_sweep(1'b1, 8, 9, 10, 11);

    // Four back-to-back k_fin with a long sweep: the fourth must be dropped.
    do_reset();
    od = 4'd7; os = 10'd3; interleave = 0;
    n_outr = 0; n_upd = 0;
    k_fin = 1;
    repeat (4) tick();
    k_fin = 0;
    repeat (40) tick();
    check("ovf_sticky", 32'(ovf), 32'd1);
    check("ovf_strobes", 32'(n_outr), 32'd24);
    check("ovf_updates", 32'(n_upd), 32'd3);
    do_reset();
    check("ovf_cleared", 32'(ovf), 32'd0);

    repeat (600) rand_tick(10, 75, 3, 0);
    repeat (300) rand_tick(60, 50, 2, 0);
    repeat (600) rand_tick(15, 60, 5, 8);

    idle_inputs();
    repeat (160) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/out_seq_ctrl.md
Name: out_seq_ctrl

Overview:
Parametrised output write-back sequencer for the conv/fc engine. Each kernel-finish pulse (k_fin) triggers one sweep over all output channels (0..od) at the current window position wi. For every channel it emits, after a fixed pipeline latency, a read-accumulate request (accr), a write strobe (outr) with address (oa), and one update pulse per sweep. It generalises the fixed-width, single-pending, channel-major output controller with these additions:
- configurable widths and latency;
- a pending-request queue with overflow detection;
- downstream back-pressure;
- an interleaved (window-major) address mode.

Parameters:
CH_W, 4, width of channel index / od
WI_W, 10, width of window index / os
AW, 12, output address width
LAT, 3, cycles from issue to outr/oa/update (legal 2..8)
PEND, 2, max queued k_fin requests (legal 1..3)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
s_init  in  1  restart window position (wi<=0)
k_fin  in  1  kernel accumulation finished; request one sweep
dst_acc  in  1  accumulate mode (qualifies accr)
interleave  in  1  0: oa=ct*os+wi; 1: oa=wi*(od+1)+ct
od  in  CH_W  last channel index (sweep = od+1 channels)
os  in  WI_W  window count per frame
out_ready  in  1  downstream may accept a new issue this cycle
outr  out  1  write strobe for oa
accr  out  1  read-accumulate request, LAT-1 cycles before matching outr
oa  out  AW  output address, valid with outr
update  out  1  one-cycle pulse with first outr of each sweep
out_busy  out  1  sweep running or request pending
ovf  out  1  sticky: k_fin dropped because queue full

Behaviour:
- Reset: state IDLE, ct=0, wi=0, pcnt=0, pipeline flushed, all outputs 0, ovf=0. Reset mid-sweep discards everything in flight.
- Pending counter pcnt (0..PEND):
  - +1 on k_fin; −1 on sweep start.
  - Both in the same cycle: pcnt unchanged.
  - k_fin with pcnt==PEND and no start that cycle: request dropped, ovf<=1 (cleared only by rst).
- FSM IDLE/RUN:
  - IDLE & pcnt!=0 -> start: latch od/os/interleave, ct<=0, RUN.
  - A k_fin at cycle t therefore gives the first issue at t+2 at the earliest.
- RUN issue rule: issue when out_ready=1; out_ready=0 holds ct and issues nothing.
  - On an issue with ct<od: ct++.
  - On an issue with ct==od (last channel): wi advances; then, if pcnt!=0, restart back-to-back (ct<=0, relatch, pcnt−1, no idle cycle); else IDLE.
- wi:
  - +1 on the last-channel issue; wraps to 0 after os−1. os==0 is treated as 1, so wi stays 0.
  - s_init forces wi<=0 and has priority over an increment in the same cycle.
- Address: computed at issue from the latched od/os/interleave; truncated modulo 2^AW. Changes to od/os/interleave mid-sweep are ignored.
- Pipeline: a LAT-deep shift of {valid, first, addr}. It always advances; out_ready gates only issue.
  - outr = valid at stage LAT.
  - oa = addr at stage LAT, held 0 when outr=0.
  - update = first at stage LAT.
  - accr = valid at stage 1 & dst_acc (dst_acc sampled at that stage).
- out_busy = (state==RUN) | (pcnt!=0). It is combinational from registers and deasserts the cycle after the last issue when nothing is pending. In-flight pipeline entries do not hold busy.

Decomposition:
- Shared package out_seq_pkg: typedef enum {IDLE,RUN}; localparam LAT_MIN=2, LAT_MAX=8, PEND_MAX=3; function out_addr(ct,wi,od,os,interleave).
- One sub-module: out_seq_pipe (parametrised LAT-stage valid/first/addr delay line with synchronous clear).

Test Plan:
- od=3, os=4, LAT=3, interleave=0, out_ready=1, single k_fin at t=0 -> outr t=5..8, oa=0,4,8,12; update only at t=5; wi=1 afterwards; out_busy low from t=6.
- Same config, interleave=1, wi=2 -> oa=8,9,10,11.
- Three k_fin pulses on consecutive cycles, PEND=2, od=1 -> 1st starts, 2nd and 3rd queued (no ovf). Three sweeps run back-to-back with no gap in outr, 6 strobes, 3 update pulses.
- PEND=1, four k_fin pulses on consecutive cycles during a sweep with od=7 -> ovf=1 and stays 1; exactly 2 sweeps (16 outr) emitted.
- out_ready low for 3 cycles mid-sweep (od=3) -> outr has a 3-cycle gap; oa sequence is unchanged and gapless in value.
- os=2: four sweeps -> wi 0,1,0,1. s_init asserted during the last issue of sweep 2 -> sweep 3 uses wi=0. rst asserted mid-sweep -> outr/update/accr 0 next cycle, wi=0, pcnt=0.
